// File: rtl/branching_buffer_pkg.sv
// Shared types and constants for the branch target buffer: sizing, the local
// 2-bit predictor encoding and its saturating training rule.
package branching_buffer_pkg;

   localparam int INDEX_W     = 10;
   localparam int ADDR_W      = 32;
   localparam int NUM_LOCAL   = 4;
   localparam int LOCAL_W     = $clog2(NUM_LOCAL);
   localparam int NUM_ENTRIES = 2 ** INDEX_W;

   typedef enum logic [1:0] {
      LP_SU = 2'b00,
      LP_WU = 2'b01,
      LP_WT = 2'b10,
      LP_ST = 2'b11
   } lp_state_t;

   localparam lp_state_t LP_RESET_STATE = LP_WU;

   // Saturating step: taken moves toward ST, not-taken toward SU.
   function automatic lp_state_t lp_train(input lp_state_t state, input logic taken);
      lp_state_t next_state;
      case (state)
         LP_SU:   next_state = taken ? LP_WU : LP_SU;
         LP_WU:   next_state = taken ? LP_WT : LP_SU;
         LP_WT:   next_state = taken ? LP_ST : LP_WU;
         LP_ST:   next_state = taken ? LP_ST : LP_WT;
         default: next_state = LP_RESET_STATE;
      endcase
      return next_state;
   endfunction

endpackage

// File: rtl/branching_buffer_local_predictor.sv
// One 2-bit saturating local branch predictor; replace forces it back to WU.
//
//   state | meaning
//   SU    | strongly not-taken
//   WU    | weakly not-taken (reset / freshly replaced entry)
//   WT    | weakly taken
//   ST    | strongly taken
module local_predictor
   import branching_buffer_pkg::*;
(
   input  logic      clk_i,
   input  logic      reset_i,
   input  logic      enable_i,
   input  logic      replace_i,
   input  logic      outcome_i,
   output lp_state_t state_o
);

   lp_state_t state_d;
   lp_state_t state_q;

   always_comb begin
      state_d = state_q;
      if (enable_i) begin
         state_d = replace_i ? LP_RESET_STATE : lp_train(state_q, outcome_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= LP_RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/branching_buffer.sv
// Direct-mapped branch target buffer: combinational fetch-side lookup, E-side
// update that either replaces an entry's target or trains one local counter.
module branching_buffer
   import branching_buffer_pkg::*;
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [ADDR_W-1:0]  pc_target_e_i,
   input  logic [INDEX_W-1:0] pc_f_i,
   input  logic [INDEX_W-1:0] pc_e,
   input  logic [LOCAL_W-1:0] local_src_i,
   input  logic               pc_src_res_e_i,
   input  logic               target_match_i,
   input  logic [1:0]         branch_op_e_i,
   output logic               pc_src_pred_f_o,
   output logic [ADDR_W-1:0]  pred_pc_target_f_o
);

   logic              update_en;
   logic              replace_en;
   logic              unused_branch_op_hi;
   logic [ADDR_W-1:0] target_d [NUM_ENTRIES];
   logic [ADDR_W-1:0] target_q [NUM_ENTRIES];
   lp_state_t         lp_state [NUM_ENTRIES][NUM_LOCAL];

   assign update_en           = branch_op_e_i[0];
   assign replace_en          = update_en & ~target_match_i;
   assign unused_branch_op_hi = branch_op_e_i[1];

   always_comb begin
      target_d = target_q;
      if (replace_en) begin
         target_d[pc_e] = pc_target_e_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            target_q[i] <= '0;
         end
      end else begin
         target_q <= target_d;
      end
   end

   // A replacement re-arms all counters of the entry; training touches only
   // the counter picked by local_src_i.
   for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
      logic entry_hit;
      assign entry_hit = update_en && (pc_e == INDEX_W'(e));

      for (genvar l = 0; l < NUM_LOCAL; l++) begin : g_local
         logic lp_en;
         assign lp_en = entry_hit && (!target_match_i || (local_src_i == LOCAL_W'(l)));

         local_predictor u_local_predictor (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .enable_i  (lp_en),
            .replace_i (!target_match_i),
            .outcome_i (pc_src_res_e_i),
            .state_o   (lp_state[e][l])
         );
      end
   end

   assign pred_pc_target_f_o = target_q[pc_f_i];
   assign pc_src_pred_f_o    = lp_state[pc_f_i][local_src_i][1];

endmodule

// File: tb/tb_branching_buffer.sv
// Scoreboard bench for branching_buffer: expectations queued as stimulus is
// driven, popped and compared against the combinational lookup.
module tb_branching_buffer;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [31:0] pc_target_e_i;
   logic [9:0]  pc_f_i;
   logic [9:0]  pc_e;
   logic [1:0]  local_src_i;
   logic        pc_src_res_e_i;
   logic        target_match_i;
   logic [1:0]  branch_op_e_i;
   logic        pc_src_pred_f_o;
   logic [31:0] pred_pc_target_f_o;

   branching_buffer dut (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .pc_target_e_i      (pc_target_e_i),
      .pc_f_i             (pc_f_i),
      .pc_e               (pc_e),
      .local_src_i        (local_src_i),
      .pc_src_res_e_i     (pc_src_res_e_i),
      .target_match_i     (target_match_i),
      .branch_op_e_i      (branch_op_e_i),
      .pc_src_pred_f_o    (pc_src_pred_f_o),
      .pred_pc_target_f_o (pred_pc_target_f_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          idx;
      int          lsrc;
      logic [31:0] tgt;
      logic        pred;
   } exp_t;

   typedef struct {
      bit          rd;
      int          idx;
      int          lsrc;
      bit          match;
      bit          taken;
      logic [31:0] tgt;
      logic        pred;
   } op_t;

   exp_t        sb[$];
   logic [31:0] tgt_m [1024];
   logic [1:0]  cnt_m [1024][4];
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic op_t rd_op(input int idx, input int lsrc, input logic [31:0] t, input logic p);
      op_t o;
      o.rd = 1'b1; o.idx = idx; o.lsrc = lsrc; o.match = 1'b0; o.taken = 1'b0;
      o.tgt = t; o.pred = p;
      return o;
   endfunction

   function automatic op_t up_op(input int idx, input int lsrc, input bit match, input bit taken,
                                 input logic [31:0] t);
      op_t o;
      o.rd = 1'b0; o.idx = idx; o.lsrc = lsrc; o.match = match; o.taken = taken;
      o.tgt = t; o.pred = 1'b0;
      return o;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 1024; i++) begin
         tgt_m[i] = '0;
         for (int l = 0; l < 4; l++) cnt_m[i][l] = 2'b01;
      end
   endfunction

   function automatic void model_upd(input int idx, input int lsrc, input bit match, input bit taken,
                                     input logic [31:0] t);
      if (!match) begin
         tgt_m[idx] = t;
         for (int l = 0; l < 4; l++) cnt_m[idx][l] = 2'b01;
      end else if (taken) begin
         if (cnt_m[idx][lsrc] != 2'b11) cnt_m[idx][lsrc] = cnt_m[idx][lsrc] + 2'b01;
      end else begin
         if (cnt_m[idx][lsrc] != 2'b00) cnt_m[idx][lsrc] = cnt_m[idx][lsrc] - 2'b01;
      end
   endfunction

   task automatic upd(input int idx, input int lsrc, input bit match, input bit taken,
                      input logic [31:0] t);
      @(negedge clk_i);
      pc_e           = 10'(idx);
      local_src_i    = 2'(lsrc);
      target_match_i = match;
      pc_src_res_e_i = taken;
      pc_target_e_i  = t;
      branch_op_e_i  = 2'b01;
      @(posedge clk_i);
      model_upd(idx, lsrc, match, taken, t);
   endtask

   task automatic run_table(input string name, input op_t ops[$]);
      exp_t e;
      foreach (ops[k]) begin
         if (ops[k].rd) begin
            sb.push_back('{ops[k].idx, ops[k].lsrc, ops[k].tgt, ops[k].pred});
            @(negedge clk_i);
            branch_op_e_i = 2'b00;
            pc_f_i        = 10'(ops[k].idx);
            local_src_i   = 2'(ops[k].lsrc);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (pred_pc_target_f_o !== e.tgt || pc_src_pred_f_o !== e.pred) begin
               n_errors++;
               $display("FAIL %s[%0d] idx=%0d src=%0d: target got %0h exp %0h, pred got %b exp %b",
                        name, k, e.idx, e.lsrc, pred_pc_target_f_o, e.tgt, pc_src_pred_f_o, e.pred);
            end
         end else begin
            upd(ops[k].idx, ops[k].lsrc, ops[k].match, ops[k].taken, ops[k].tgt);
         end
      end
   endtask

   task automatic test_reset();
      op_t ops[$];
      @(negedge clk_i);
      reset_i        = 1'b1;
      branch_op_e_i  = 2'b01;
      target_match_i = 1'b0;
      pc_e           = 10'd3;
      pc_target_e_i  = 32'd77;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i       = 1'b0;
      branch_op_e_i = 2'b00;
      model_reset();
      ops.push_back(rd_op(0, 0, 0, 0));
      for (int l = 0; l < 4; l++) ops.push_back(rd_op(3, l, 0, 0));
      ops.push_back(rd_op(1023, 2, 0, 0));
      ops.push_back(rd_op(512, 1, 0, 0));
      run_table("reset", ops);
   endtask

   task automatic test_fill();
      exp_t e;
      for (int i = 0; i < 1024; i++) upd(i, 0, 1'b0, 1'b0, 32'(i));
      for (int i = 0; i < 1024; i++) begin
         sb.push_back('{i, i % 4, 32'(i), 1'b0});
         @(negedge clk_i);
         branch_op_e_i = 2'b00;
         pc_f_i        = 10'(i);
         local_src_i   = 2'(i % 4);
         #1;
         e = sb.pop_front();
         n_checks++;
         if (pred_pc_target_f_o !== e.tgt || pc_src_pred_f_o !== e.pred) begin
            n_errors++;
            $display("FAIL fill idx=%0d: target got %0h exp %0h, pred got %b exp %b",
                     e.idx, pred_pc_target_f_o, e.tgt, pc_src_pred_f_o, e.pred);
         end
      end
   endtask

   task automatic test_training();
      op_t ops[$];
      ops = '{up_op(0,0,1,1,0), rd_op(0,0,0,1),
              up_op(0,0,1,0,0), rd_op(0,0,0,0),
              up_op(0,0,1,1,0), up_op(0,0,1,1,0), rd_op(0,0,0,1),
              up_op(0,0,1,1,0), rd_op(0,0,0,1),
              up_op(0,0,1,0,0), rd_op(0,0,0,1),
              up_op(0,0,1,1,0), rd_op(0,0,0,1),
              rd_op(0,1,0,0), rd_op(0,3,0,0),
              up_op(1,0,1,1,0), up_op(1,0,1,1,0), rd_op(1,0,1,1),
              up_op(2,0,1,0,0), up_op(2,0,1,0,0), up_op(2,0,1,0,0), rd_op(2,0,2,0),
              up_op(2,0,1,1,0), rd_op(2,0,2,0),
              up_op(2,0,1,1,0), rd_op(2,0,2,1)};
      run_table("training", ops);
   endtask

   task automatic test_replace();
      op_t ops[$];
      ops = '{up_op(0,0,0,0,1000),
              rd_op(0,0,1000,0), rd_op(0,1,1000,0), rd_op(0,2,1000,0), rd_op(0,3,1000,0),
              rd_op(1,0,1,1),
              up_op(0,0,1,1,0), rd_op(0,0,1000,1)};
      run_table("replace", ops);
   endtask

   task automatic test_local_src();
      op_t ops[$];
      ops = '{rd_op(1,1,1,0), rd_op(1,0,1,1), rd_op(1,2,1,0),
              up_op(1,2,1,1,0), up_op(1,2,1,1,0),
              rd_op(1,2,1,1), rd_op(1,3,1,0), rd_op(1,1,1,0), rd_op(1,0,1,1)};
      run_table("local_src", ops);
   endtask

   task automatic test_post_replace();
      op_t ops[$];
      ops = '{up_op(100,1,0,1,1001), rd_op(100,1,1001,0),
              up_op(100,1,1,1,0), up_op(100,1,1,1,0), rd_op(100,1,1001,1),
              up_op(100,0,1,0,0), rd_op(100,0,1001,0),
              up_op(100,0,1,1,0), up_op(100,0,1,1,0), rd_op(100,0,1001,1),
              up_op(100,0,1,0,0), rd_op(100,0,1001,0),
              rd_op(100,1,1001,1), rd_op(100,2,1001,0), rd_op(101,0,101,0)};
      run_table("post_replace", ops);
   endtask

   // Update held on every cycle while reading the same index: the read must
   // show the pre-edge value each cycle.
   task automatic test_back_to_back();
      bit          c_match [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      bit          c_taken [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] c_tgt   [5] = '{32'hDEAD, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [31:0] pre_tgt [5] = '{32'd5, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
      logic        pre_pred[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_t        e;
      for (int c = 0; c < 5; c++) begin
         sb.push_back('{5, 3, pre_tgt[c], pre_pred[c]});
         @(negedge clk_i);
         pc_e           = 10'd5;
         pc_f_i         = 10'd5;
         local_src_i    = 2'd3;
         target_match_i = c_match[c];
         pc_src_res_e_i = c_taken[c];
         pc_target_e_i  = c_tgt[c];
         branch_op_e_i  = 2'b01;
         #1;
         e = sb.pop_front();
         n_checks++;
         if (pred_pc_target_f_o !== e.tgt || pc_src_pred_f_o !== e.pred) begin
            n_errors++;
            $display("FAIL back_to_back cycle=%0d: target got %0h exp %0h, pred got %b exp %b",
                     c, pred_pc_target_f_o, e.tgt, pc_src_pred_f_o, e.pred);
         end
         @(posedge clk_i);
         model_upd(5, 3, c_match[c], c_taken[c], c_tgt[c]);
      end
      sb.push_back('{5, 3, 32'hDEAD, 1'b0});
      @(negedge clk_i);
      branch_op_e_i = 2'b00;
      #1;
      e = sb.pop_front();
      n_checks++;
      if (pred_pc_target_f_o !== e.tgt || pc_src_pred_f_o !== e.pred) begin
         n_errors++;
         $display("FAIL back_to_back final: target got %0h exp %0h, pred got %b exp %b",
                  pred_pc_target_f_o, e.tgt, pc_src_pred_f_o, e.pred);
      end
   endtask

   task automatic test_disable();
      exp_t e;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk_i);
         branch_op_e_i  = 2'b10;
         pc_e           = 10'($urandom_range(0, 1023));
         local_src_i    = 2'($urandom_range(0, 3));
         target_match_i = 1'($urandom_range(0, 1));
         pc_src_res_e_i = 1'($urandom_range(0, 1));
         pc_target_e_i  = $urandom;
         @(posedge clk_i);
      end
      for (int i = 0; i < 1024; i++) begin
         sb.push_back('{i, (i * 3) % 4, tgt_m[i], cnt_m[i][(i * 3) % 4][1]});
         @(negedge clk_i);
         branch_op_e_i = 2'b00;
         pc_f_i        = 10'(i);
         local_src_i   = 2'((i * 3) % 4);
         #1;
         e = sb.pop_front();
         n_checks++;
         if (pred_pc_target_f_o !== e.tgt || pc_src_pred_f_o !== e.pred) begin
            n_errors++;
            $display("FAIL disable idx=%0d src=%0d: target got %0h exp %0h, pred got %b exp %b",
                     e.idx, e.lsrc, pred_pc_target_f_o, e.tgt, pc_src_pred_f_o, e.pred);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      upd(7, 0, 1'b1, 1'b1, 32'h0);
      @(negedge clk_i);
      reset_i        = 1'b1;
      branch_op_e_i  = 2'b01;
      target_match_i = 1'b0;
      pc_e           = 10'd1;
      pc_target_e_i  = 32'd123;
      @(posedge clk_i);
      model_reset();
      @(negedge clk_i);
      reset_i       = 1'b0;
      branch_op_e_i = 2'b00;
      for (int i = 0; i < 1024; i++) begin
         sb.push_back('{i, i % 4, tgt_m[i], cnt_m[i][i % 4][1]});
         @(negedge clk_i);
         pc_f_i      = 10'(i);
         local_src_i = 2'(i % 4);
         #1;
         e = sb.pop_front();
         n_checks++;
         if (pred_pc_target_f_o !== e.tgt || pc_src_pred_f_o !== e.pred) begin
            n_errors++;
            $display("FAIL reset_mid idx=%0d src=%0d: target got %0h exp %0h, pred got %b exp %b",
                     e.idx, e.lsrc, pred_pc_target_f_o, e.tgt, pc_src_pred_f_o, e.pred);
         end
      end
   endtask

   initial begin
      reset_i        = 1'b1;
      pc_target_e_i  = '0;
      pc_f_i         = '0;
      pc_e           = '0;
      local_src_i    = '0;
      pc_src_res_e_i = 1'b0;
      target_match_i = 1'b0;
      branch_op_e_i  = 2'b00;
      model_reset();

      test_reset();
      test_fill();
      test_training();
      test_replace();
      test_local_src();
      test_post_replace();
      test_back_to_back();
      test_disable();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
